// File: rtl/conv_stage2_pkg.sv
// Shared configuration for the stage-2 adder arbiter: default widths and
// the helper that sizes requester-index fields.
package conv_stage2_pkg;

    localparam int DW_DEFAULT    = 16;
    localparam int N_REQ_DEFAULT = 4;

    // Width of an index able to name n requesters; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adder3_sat.sv
// Combinational 3-operand signed adder. The result is DW+2 bits wide, which
// holds the exact sum of three DW-bit operands. Build option
// ADDER_STAGE2_SAT_EN clamps the sum to the DW-bit signed range. The clamped
// value is then sign-extended back to DW+2 bits.
module adder3_sat #(
    parameter int DW = 16
) (
    input  logic signed [DW-1:0] op1,
    input  logic signed [DW-1:0] op2,
    input  logic signed [DW-1:0] op3,
    output logic signed [DW+1:0] sum
);

    logic signed [DW+1:0] exact;

    // Two guard bits make the sum exact: |3 * -2^(DW-1)| < 2^(DW+1).
    assign exact = {{2{op1[DW-1]}}, op1} + {{2{op2[DW-1]}}, op2} + {{2{op3[DW-1]}}, op3};

`ifdef ADDER_STAGE2_SAT_EN
    localparam logic signed [DW+1:0] SAT_MAX = {3'b000, {(DW-1){1'b1}}};
    localparam logic signed [DW+1:0] SAT_MIN = {3'b111, {(DW-1){1'b0}}};

    // Clamp the exact sum into the DW-bit signed range.
    always_comb begin
        if (exact > SAT_MAX) begin
            sum = SAT_MAX;
        end else if (exact < SAT_MIN) begin
            sum = SAT_MIN;
        end else begin
            sum = exact;
        end
    end
`else
    assign sum = exact;
`endif

endmodule

// File: rtl/adder_stage2_arbiter.sv
// Round-robin arbiter in front of one shared, registered 3-input signed
// adder. Up to N_REQ requesters each offer an {op3,op2,op1} triple. One
// requester is granted per cycle, and only while the output slot is free.
// The registered sum is tagged with the index of the requester that owns it.
// Build option ADDER_STAGE2_SAT_EN saturates the sum inside adder3_sat.
module adder_stage2_arbiter
    import conv_stage2_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEFAULT,
    parameter int DW    = DW_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*3*DW-1:0]      req_data,
    output logic [N_REQ-1:0]           req_ready,
    output logic                       out_valid,
    output logic [DW+1:0]              out_data,
    output logic [id_width(N_REQ)-1:0] out_id,
    input  logic                       out_ready
);

    localparam int IDW = id_width(N_REQ);

    logic [IDW-1:0]       ptr;
    logic [IDW-1:0]       grant_idx;
    logic [IDW-1:0]       idx;
    logic                 grant_found;
    logic                 slot_free;
    logic                 transfer;
    logic [3*DW-1:0]      sel_data;
    logic signed [DW+1:0] sum;

    // A result can be loaded when the register is empty or is draining this cycle.
    assign slot_free = !out_valid || out_ready;

    // Round-robin search: the first valid requester at or after ptr wins.
    always_comb begin
        // NOTE: every variable gets a default before the loop, so no path through the block infers a latch.
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = IDW'((int'(ptr) + k) % N_REQ);
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_idx   = idx;
            end
        end
    end

    // Grant strobe: one-hot and only while the slot is free. It is held low during reset.
    always_comb begin
        req_ready = '0;
        if (rst_n && slot_free && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign transfer = |req_ready;
    assign sel_data = req_data[int'(grant_idx)*3*DW +: 3*DW];

    adder3_sat #(
        .DW (DW)
    ) u_adder3_sat (
        .op1 (sel_data[DW-1:0]),
        .op2 (sel_data[2*DW-1:DW]),
        .op3 (sel_data[3*DW-1:2*DW]),
        .sum (sum)
    );

    // Output register and pointer: load on transfer, clear valid on a bare drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
            ptr       <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register here samples pre-edge values.
            if (transfer) begin
                out_valid <= 1'b1;
                out_data  <= sum;
                out_id    <= grant_idx;
                ptr       <= (int'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
